v_strip_exec: RTL and testbench

- Multi-cycle vector execution sequencer; next generation of the single-cycle vector datapath.
- Accepts one decoded vector op per valid/ready handshake and strip-mines it over the vector in beats of LANES elements.
- Reads and writes the vector regfile one beat per cycle; moves data to and from VRAM through a req/ack handshake.
- Sits between the vector decoder and the vector regfile/VRAM; replaces the fixed one-shot id/alu/mem/wb chain.

---
 rtl/v_strip_exec.sv | 225 ++++++++++++++++++++++
 tb/tb_v_strip_exec.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_strip_exec.sv
// Multi-cycle vector sequencer: strip-mines one decoded op over the register in LANES-wide beats.
// Optional saturating ops (VSADD/VSSUB) are built when V_SAT_EN is defined.

module v_strip_lane #(
   parameter int ELEN = 32,
   parameter int IW   = 6
) (
   input  logic [2:0]      op,
   input  logic [ELEN-1:0] a,
   input  logic [ELEN-1:0] b,
   input  logic [IW-1:0]   idx,
   input  logic [IW-1:0]   vl,
   output logic [ELEN-1:0] res,
   output logic            en
);

   logic [ELEN-1:0] prod;

   // Low ELEN bits of a product do not depend on operand signedness.
   assign prod = a * b;
   assign en   = (idx < vl);

`ifdef V_SAT_EN
   logic [ELEN:0] sadd;
   logic [ELEN:0] ssub;

   assign sadd = {a[ELEN-1], a} + {b[ELEN-1], b};
   assign ssub = {a[ELEN-1], a} - {b[ELEN-1], b};

   // One guard bit: a mismatch with the sign bit means the result left the signed range.
   function automatic logic [ELEN-1:0] sat(input logic [ELEN:0] x);
      if (x[ELEN] != x[ELEN-1])
         return x[ELEN] ? {1'b1, {(ELEN-1){1'b0}}} : {1'b0, {(ELEN-1){1'b1}}};
      return x[ELEN-1:0];
   endfunction
`endif

   always_comb begin
      res = a + b;
      case (op)
         3'd1:    res = a - b;
         3'd2:    res = prod;
`ifdef V_SAT_EN
         3'd5:    res = sat(sadd);
         3'd6:    res = sat(ssub);
`endif
         default: res = a + b;
      endcase
   end

endmodule

module v_strip_exec #(
   parameter  int VLEN    = 512,
   parameter  int ELEN    = 32,
   parameter  int LANES   = 4,
   parameter  int VREG_AW = 5,
   parameter  int VRAM_AW = 32,
   localparam int VLMAX   = VLEN / ELEN,
   localparam int NBEAT   = VLMAX / LANES,
   localparam int BW      = LANES * ELEN,
   localparam int BEAT_AW = (NBEAT > 1) ? $clog2(NBEAT) : 1,
   localparam int VL_W    = $clog2(VLMAX) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [2:0]         op_code,
   input  logic [VREG_AW-1:0] op_vd,
   input  logic [VREG_AW-1:0] op_vs1,
   input  logic [VREG_AW-1:0] op_vs2,
   input  logic [VRAM_AW-1:0] op_base,
   input  logic [VL_W-1:0]    op_vl,
   output logic [VREG_AW-1:0] vrf_rd_addr,
   output logic [VREG_AW-1:0] vrf_rd2_addr,
   output logic [BEAT_AW-1:0] vrf_rd_beat,
   input  logic [BW-1:0]      vrf_rs1_data,
   input  logic [BW-1:0]      vrf_rs2_data,
   output logic               vrf_we,
   output logic [VREG_AW-1:0] vrf_wr_addr,
   output logic [BEAT_AW-1:0] vrf_wr_beat,
   output logic [BW-1:0]      vrf_wr_data,
   output logic [LANES-1:0]   vrf_wr_lmask,
   output logic               vram_req,
   output logic               vram_we,
   output logic [VRAM_AW-1:0] vram_addr,
   output logic [BW-1:0]      vram_wdata,
   output logic [BW-1:0]      vram_wmask,
   input  logic               vram_ack,
   input  logic [BW-1:0]      vram_rdata,
   output logic               done,
   output logic               err
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MREQ, S_DONE} state_e;

   typedef enum logic [2:0] {
      OP_VADD  = 3'd0,
      OP_VSUB  = 3'd1,
      OP_VMUL  = 3'd2,
      OP_VLE   = 3'd3,
      OP_VSE   = 3'd4,
      OP_VSADD = 3'd5,
      OP_VSSUB = 3'd6,
      OP_ILL   = 3'd7
   } opc_e;

   typedef struct packed {
      logic [2:0]         opc;
      logic [VREG_AW-1:0] vd;
      logic [VREG_AW-1:0] vs1;
      logic [VREG_AW-1:0] vs2;
      logic [VRAM_AW-1:0] base;
      logic [VL_W-1:0]    vl;
   } op_t;

   state_e                       state;
   op_t                          op_q;
   logic [BEAT_AW-1:0]           beat;
   logic                         ill_q;

   logic                         op_ill;
   logic [VL_W-1:0]              vl_clamp;
   logic [VL_W:0]                beat_base;
   logic [VL_W:0]                beat_end;
   logic                         last_beat;
   logic                         in_exec;
   logic                         in_mreq;
   logic                         is_st;
   logic [LANES-1:0][ELEN-1:0]   alu_res;
   logic [LANES-1:0]             lane_en;
   logic [BW-1:0]                mask_exp;

   always_comb begin
      op_ill = (op_code == OP_ILL);
`ifndef V_SAT_EN
      if (op_code == OP_VSADD || op_code == OP_VSSUB)
         op_ill = 1'b1;
`endif
   end

   assign vl_clamp  = (op_vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : op_vl;
   assign beat_base = (VL_W+1)'(beat) * (VL_W+1)'(LANES);
   assign beat_end  = beat_base + (VL_W+1)'(LANES);
   assign last_beat = (beat_end >= {1'b0, op_q.vl});

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      v_strip_lane #(.ELEN(ELEN), .IW(VL_W+1)) u_lane (
         .op  (op_q.opc),
         .a   (vrf_rs1_data[l*ELEN +: ELEN]),
         .b   (vrf_rs2_data[l*ELEN +: ELEN]),
         .idx (beat_base + (VL_W+1)'(l)),
         .vl  ({1'b0, op_q.vl}),
         .res (alu_res[l]),
         .en  (lane_en[l])
      );
      assign mask_exp[l*ELEN +: ELEN] = {ELEN{lane_en[l]}};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         op_q  <= '0;
         beat  <= '0;
         ill_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (op_valid) begin
               op_q.opc  <= op_code;
               op_q.vd   <= op_vd;
               op_q.vs1  <= op_vs1;
               op_q.vs2  <= op_vs2;
               op_q.base <= op_base;
               op_q.vl   <= vl_clamp;
               beat      <= '0;
               ill_q     <= op_ill;
               if (op_ill || vl_clamp == '0)
                  state <= S_DONE;
               else if (op_code == OP_VLE || op_code == OP_VSE)
                  state <= S_MREQ;
               else
                  state <= S_EXEC;
            end
            S_EXEC: begin
               if (last_beat) state <= S_DONE;
               else           beat  <= beat + 1'b1;
            end
            // The request stays up across beats; only the ack advances the beat.
            S_MREQ: if (vram_ack) begin
               if (last_beat) state <= S_DONE;
               else           beat  <= beat + 1'b1;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_exec = (state == S_EXEC);
   assign in_mreq = (state == S_MREQ);
   assign is_st   = (op_q.opc == OP_VSE);

   assign op_ready = rst && (state == S_IDLE);
   assign done     = (state == S_DONE);
   assign err      = done && ill_q;

   assign vrf_rd_addr  = in_exec ? op_q.vs1 : ((in_mreq && is_st) ? op_q.vd : '0);
   assign vrf_rd2_addr = in_exec ? op_q.vs2 : '0;
   assign vrf_rd_beat  = (in_exec || in_mreq) ? beat : '0;

   // Loads write back in the ack cycle, so rdata never needs a holding register.
   assign vrf_we       = in_exec || (in_mreq && !is_st && vram_ack);
   assign vrf_wr_addr  = vrf_we ? op_q.vd : '0;
   assign vrf_wr_beat  = vrf_we ? beat : '0;
   assign vrf_wr_data  = in_exec ? alu_res : (vrf_we ? vram_rdata : '0);
   assign vrf_wr_lmask = vrf_we ? lane_en : '0;

   assign vram_req   = in_mreq;
   assign vram_we    = in_mreq && is_st;
   assign vram_addr  = in_mreq ? (op_q.base + VRAM_AW'(beat) * VRAM_AW'(BW/8)) : '0;
   assign vram_wdata = vram_we ? vrf_rs1_data : '0;
   assign vram_wmask = vram_we ? mask_exp : '0;

endmodule

// File: tb/tb_v_strip_exec.sv
// Directed bench for v_strip_exec: regfile and VRAM models, one task per scenario.
// Saturation scenario is compiled in when V_SAT_EN is defined.

module tb_v_strip_exec;

   localparam int VLEN = 512, ELEN = 32, LANES = 4, VREG_AW = 5, VRAM_AW = 32;
   localparam int VLMAX = 16, NBEAT = 4, BW = 128, BEAT_AW = 2, VL_W = 5;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               op_valid = 1'b0;
   logic               op_ready;
   logic [2:0]         op_code = '0;
   logic [VREG_AW-1:0] op_vd = '0, op_vs1 = '0, op_vs2 = '0;
   logic [VRAM_AW-1:0] op_base = '0;
   logic [VL_W-1:0]    op_vl = '0;
   logic [VREG_AW-1:0] vrf_rd_addr, vrf_rd2_addr, vrf_wr_addr;
   logic [BEAT_AW-1:0] vrf_rd_beat, vrf_wr_beat;
   logic [BW-1:0]      vrf_rs1_data, vrf_rs2_data, vrf_wr_data;
   logic               vrf_we;
   logic [LANES-1:0]   vrf_wr_lmask;
   logic               vram_req, vram_we, vram_ack;
   logic [VRAM_AW-1:0] vram_addr;
   logic [BW-1:0]      vram_wdata, vram_wmask, vram_rdata;
   logic               done, err;

   int checks = 0;
   int failures = 0;

   v_strip_exec #(.VLEN(VLEN), .ELEN(ELEN), .LANES(LANES), .VREG_AW(VREG_AW), .VRAM_AW(VRAM_AW)) dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
      .op_vd(op_vd), .op_vs1(op_vs1), .op_vs2(op_vs2), .op_base(op_base), .op_vl(op_vl),
      .vrf_rd_addr(vrf_rd_addr), .vrf_rd2_addr(vrf_rd2_addr), .vrf_rd_beat(vrf_rd_beat),
      .vrf_rs1_data(vrf_rs1_data), .vrf_rs2_data(vrf_rs2_data),
      .vrf_we(vrf_we), .vrf_wr_addr(vrf_wr_addr), .vrf_wr_beat(vrf_wr_beat),
      .vrf_wr_data(vrf_wr_data), .vrf_wr_lmask(vrf_wr_lmask),
      .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
      .vram_wdata(vram_wdata), .vram_wmask(vram_wmask),
      .vram_ack(vram_ack), .vram_rdata(vram_rdata),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Regfile model with a preload port driven by the stimulus
   logic [BW-1:0]      vrf [32][NBEAT];
   logic               pl_we = 1'b0;
   logic [4:0]         pl_addr = '0;
   logic [1:0]         pl_beat = '0;
   logic [BW-1:0]      pl_data = '0;

   assign vrf_rs1_data = vrf[vrf_rd_addr][vrf_rd_beat];
   assign vrf_rs2_data = vrf[vrf_rd2_addr][vrf_rd_beat];

   // VRAM model: ack after ack_delay waiting cycles, rdata derived from address
   int ack_delay = 0;
   int wait_cnt = 0;
   assign vram_ack = vram_req && (wait_cnt >= ack_delay);
   for (genvar l = 0; l < LANES; l++) begin : g_rd
      assign vram_rdata[l*ELEN +: ELEN] = 32'hA000_0000 | (vram_addr + 32'(l));
   end

   int                 wcnt = 0, rcnt = 0;
   logic [3:0]         wlog_mask [64];
   logic [1:0]         wlog_beat [64];
   logic [31:0]        rlog_addr [64];
   logic               rlog_we   [64];
   logic [BW-1:0]      rlog_wdata[64];
   logic [BW-1:0]      rlog_wmask[64];

   always @(posedge clk) begin
      if (pl_we) vrf[pl_addr][pl_beat] <= pl_data;
      if (vrf_we) begin
         for (int l = 0; l < LANES; l++)
            if (vrf_wr_lmask[l]) vrf[vrf_wr_addr][vrf_wr_beat][l*ELEN +: ELEN] <= vrf_wr_data[l*ELEN +: ELEN];
         wlog_mask[wcnt[5:0]] <= vrf_wr_lmask;
         wlog_beat[wcnt[5:0]] <= vrf_wr_beat;
         wcnt <= wcnt + 1;
      end
      if (vram_req && vram_ack) begin
         rlog_addr[rcnt[5:0]]  <= vram_addr;
         rlog_we[rcnt[5:0]]    <= vram_we;
         rlog_wdata[rcnt[5:0]] <= vram_wdata;
         rlog_wmask[rcnt[5:0]] <= vram_wmask;
         rcnt <= rcnt + 1;
      end
      if (!vram_req || vram_ack) wait_cnt <= 0;
      else                       wait_cnt <= wait_cnt + 1;
   end

   function automatic logic [31:0] elem(input int r, input int i);
      return vrf[r][i / LANES][(i % LANES)*ELEN +: ELEN];
   endfunction

   task automatic preload(input int r, input logic [31:0] v0, input logic [31:0] step);
      for (int b = 0; b < NBEAT; b++) begin
         @(negedge clk);
         pl_we = 1'b1; pl_addr = 5'(r); pl_beat = 2'(b);
         for (int l = 0; l < LANES; l++) pl_data[l*ELEN +: ELEN] = v0 + step * 32'(b*LANES + l);
      end
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic issue_op(input logic [2:0] opc, input int vd, input int vs1, input int vs2,
                           input logic [31:0] base, input int vl);
      @(negedge clk);
      op_code = opc; op_vd = 5'(vd); op_vs1 = 5'(vs1); op_vs2 = 5'(vs2);
      op_base = base; op_vl = 5'(vl); op_valid = 1'b1;
      @(posedge clk);
   endtask

   // cyc = index of the falling edge after acceptance at which done is seen; 0 on timeout
   task automatic wait_done(output int cyc, output logic e);
      cyc = 0; e = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (n == 1) op_valid = 1'b0;
         if (done) begin cyc = n; e = err; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL reset_op_ready got=%0b exp=0", op_ready); end
      checks++; if (vrf_we !== 1'b0 || vram_req !== 1'b0 || vram_we !== 1'b0) begin
         failures++; $display("FAIL reset_we_req got=%0b%0b%0b exp=000", vrf_we, vram_req, vram_we); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%0b%0b exp=00", done, err); end
      checks++; if (vram_addr !== '0 || vrf_wr_data !== '0 || vram_wmask !== '0 || vrf_wr_lmask !== '0) begin
         failures++; $display("FAIL reset_outputs addr=%0h wdata=%0h wmask=%0h lmask=%0h exp=0", vram_addr, vrf_wr_data, vram_wmask, vrf_wr_lmask); end
      rst = 1'b1;
      #1;
      checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", op_ready); end
   endtask

   task automatic test_vadd;
      int cyc, w0; logic e;
      preload(1, 32'd0, 32'd1);
      preload(2, 32'd100, 32'd0);
      w0 = wcnt;
      issue_op(3'd0, 3, 1, 2, 32'h0, 16);
      wait_done(cyc, e);
      checks++; if (cyc !== 5) begin failures++; $display("FAIL vadd_done_cycle got=%0d exp=5", cyc); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL vadd_err got=%0b exp=0", e); end
      checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL vadd_ready_in_done got=%0b exp=0", op_ready); end
      checks++; if (wcnt - w0 !== 4) begin failures++; $display("FAIL vadd_write_count got=%0d exp=4", wcnt - w0); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (wlog_mask[w0+k] !== 4'hF || wlog_beat[w0+k] !== 2'(k)) begin
            failures++; $display("FAIL vadd_beat%0d mask=%0h beat=%0d exp mask=f beat=%0d", k, wlog_mask[w0+k], wlog_beat[w0+k], k); end
      end
      for (int i = 0; i < 16; i++) begin
         checks++; if (elem(3, i) !== 32'(100 + i)) begin
            failures++; $display("FAIL vadd_elem%0d got=%0h exp=%0h", i, elem(3, i), 100 + i); end
      end
      @(negedge clk);
      checks++; if (done !== 1'b0 || op_ready !== 1'b1) begin
         failures++; $display("FAIL vadd_after_done done=%0b ready=%0b exp done=0 ready=1", done, op_ready); end
   endtask

   task automatic test_vsub_vmul;
      int cyc, w0; logic e;
      preload(4, 32'd0, 32'd0);
      preload(5, 32'd1, 32'd0);
      preload(6, 32'h5555_5555, 32'd0);
      preload(7, 32'h0001_0000, 32'd0);
      preload(8, 32'h5555_5555, 32'd0);
      w0 = wcnt;
      issue_op(3'd1, 6, 4, 5, 32'h0, 6);
      wait_done(cyc, e);
      checks++; if (cyc !== 3) begin failures++; $display("FAIL vsub_done_cycle got=%0d exp=3", cyc); end
      checks++; if (wcnt - w0 !== 2) begin failures++; $display("FAIL vsub_write_count got=%0d exp=2", wcnt - w0); end
      checks++; if (wlog_mask[w0] !== 4'hF || wlog_mask[w0+1] !== 4'h3) begin
         failures++; $display("FAIL vsub_lmask got=%0h,%0h exp=f,3", wlog_mask[w0], wlog_mask[w0+1]); end
      for (int i = 0; i < 6; i++) begin
         checks++; if (elem(6, i) !== 32'hFFFF_FFFF) begin failures++; $display("FAIL vsub_elem%0d got=%0h exp=ffffffff", i, elem(6, i)); end
      end
      checks++; if (elem(6, 6) !== 32'h5555_5555 || elem(6, 15) !== 32'h5555_5555) begin
         failures++; $display("FAIL vsub_tail got=%0h,%0h exp=55555555", elem(6, 6), elem(6, 15)); end
      w0 = wcnt;
      issue_op(3'd2, 8, 7, 7, 32'h0, 6);
      wait_done(cyc, e);
      checks++; if (wcnt - w0 !== 2 || wlog_mask[w0+1] !== 4'h3) begin
         failures++; $display("FAIL vmul_writes got=%0d mask1=%0h exp=2 mask1=3", wcnt - w0, wlog_mask[w0+1]); end
      checks++; if (elem(8, 0) !== 32'h0 || elem(8, 5) !== 32'h0 || elem(8, 6) !== 32'h5555_5555) begin
         failures++; $display("FAIL vmul_elems got=%0h,%0h,%0h exp=0,0,55555555", elem(8, 0), elem(8, 5), elem(8, 6)); end
   endtask

   task automatic test_vle;
      int cyc, w0, r0, bad; logic [31:0] a_exp;
      ack_delay = 3; w0 = wcnt; r0 = rcnt; cyc = 0; bad = 0;
      issue_op(3'd3, 10, 0, 0, 32'h100, 8);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) op_valid = 1'b0;
         if (done) begin cyc = n; break; end
         a_exp = (n <= 4) ? 32'h100 : 32'h110;
         if (vram_req !== 1'b1 || vram_we !== 1'b0 || vram_addr !== a_exp) bad++;
      end
      checks++; if (cyc !== 9) begin failures++; $display("FAIL vle_done_cycle got=%0d exp=9", cyc); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL vle_req_stable bad_cycles=%0d exp=0", bad); end
      checks++; if (rcnt - r0 !== 2 || rlog_addr[r0] !== 32'h100 || rlog_addr[r0+1] !== 32'h110) begin
         failures++; $display("FAIL vle_addrs n=%0d a0=%0h a1=%0h exp n=2 a0=100 a1=110", rcnt - r0, rlog_addr[r0], rlog_addr[r0+1]); end
      checks++; if (wcnt - w0 !== 2 || wlog_mask[w0] !== 4'hF || wlog_mask[w0+1] !== 4'hF) begin
         failures++; $display("FAIL vle_writes n=%0d exp=2 masks=f", wcnt - w0); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (elem(10, i) !== ((i < 4) ? 32'hA000_0100 + 32'(i) : 32'hA000_0110 + 32'(i - 4))) begin
            failures++; $display("FAIL vle_elem%0d got=%0h", i, elem(10, i)); end
      end
   endtask

   task automatic test_vse;
      int cyc, w0, r0; logic e;
      ack_delay = 0; w0 = wcnt; r0 = rcnt;
      issue_op(3'd4, 3, 0, 0, 32'h200, 5);
      wait_done(cyc, e);
      checks++; if (cyc !== 3) begin failures++; $display("FAIL vse_done_cycle got=%0d exp=3", cyc); end
      checks++; if (rcnt - r0 !== 2 || wcnt - w0 !== 0) begin
         failures++; $display("FAIL vse_counts req=%0d wr=%0d exp req=2 wr=0", rcnt - r0, wcnt - w0); end
      checks++; if (rlog_addr[r0] !== 32'h200 || rlog_addr[r0+1] !== 32'h210 || rlog_we[r0] !== 1'b1 || rlog_we[r0+1] !== 1'b1) begin
         failures++; $display("FAIL vse_addr_we a0=%0h a1=%0h exp 200,210 we=1", rlog_addr[r0], rlog_addr[r0+1]); end
      checks++; if (rlog_wdata[r0] !== {32'd103, 32'd102, 32'd101, 32'd100} || rlog_wdata[r0+1] !== {32'd107, 32'd106, 32'd105, 32'd104}) begin
         failures++; $display("FAIL vse_wdata got=%0h,%0h", rlog_wdata[r0], rlog_wdata[r0+1]); end
      checks++; if (rlog_wmask[r0] !== {BW{1'b1}} || rlog_wmask[r0+1] !== {96'h0, 32'hFFFF_FFFF}) begin
         failures++; $display("FAIL vse_wmask got=%0h,%0h exp=all-ones,ffffffff", rlog_wmask[r0], rlog_wmask[r0+1]); end
   endtask

   task automatic test_edges;
      int cyc, w0, r0; logic e;
      w0 = wcnt; r0 = rcnt;
      issue_op(3'd0, 20, 1, 2, 32'h0, 0);
      wait_done(cyc, e);
      checks++; if (cyc !== 1 || e !== 1'b0) begin failures++; $display("FAIL vl0 cyc=%0d err=%0b exp cyc=1 err=0", cyc, e); end
      issue_op(3'd7, 20, 1, 2, 32'h0, 8);
      wait_done(cyc, e);
      checks++; if (cyc !== 1 || e !== 1'b1) begin failures++; $display("FAIL op7 cyc=%0d err=%0b exp cyc=1 err=1", cyc, e); end
      issue_op(3'd3, 20, 0, 0, 32'h400, 0);
      wait_done(cyc, e);
      checks++; if (wcnt - w0 !== 0 || rcnt - r0 !== 0) begin
         failures++; $display("FAIL edge_no_traffic wr=%0d req=%0d exp=0,0", wcnt - w0, rcnt - r0); end
      w0 = wcnt;
      issue_op(3'd0, 13, 1, 2, 32'h0, 31);
      wait_done(cyc, e);
      checks++; if (cyc !== 5 || wcnt - w0 !== 4) begin failures++; $display("FAIL vl_clamp cyc=%0d wr=%0d exp cyc=5 wr=4", cyc, wcnt - w0); end
      checks++; if (elem(13, 15) !== 32'd115) begin failures++; $display("FAIL vl_clamp_elem got=%0h exp=73", elem(13, 15)); end
   endtask

   task automatic test_sat;
      int cyc, w0; logic e;
      w0 = wcnt;
`ifdef V_SAT_EN
      preload(14, 32'h7FFF_FFFF, 32'd0);
      preload(15, 32'd1, 32'd0);
      preload(17, 32'h8000_0000, 32'd0);
      issue_op(3'd5, 16, 14, 15, 32'h0, 4);
      wait_done(cyc, e);
      checks++; if (cyc !== 2 || e !== 1'b0) begin failures++; $display("FAIL vsadd_timing cyc=%0d err=%0b exp 2,0", cyc, e); end
      checks++; if (elem(16, 0) !== 32'h7FFF_FFFF || elem(16, 3) !== 32'h7FFF_FFFF) begin
         failures++; $display("FAIL vsadd_sat got=%0h exp=7fffffff", elem(16, 0)); end
      issue_op(3'd6, 18, 17, 15, 32'h0, 4);
      wait_done(cyc, e);
      checks++; if (elem(18, 0) !== 32'h8000_0000) begin failures++; $display("FAIL vssub_sat got=%0h exp=80000000", elem(18, 0)); end
`else
      issue_op(3'd5, 16, 1, 2, 32'h0, 4);
      wait_done(cyc, e);
      checks++; if (cyc !== 1 || e !== 1'b1 || wcnt - w0 !== 0) begin
         failures++; $display("FAIL op5_illegal cyc=%0d err=%0b wr=%0d exp 1,1,0", cyc, e, wcnt - w0); end
`endif
   endtask

   task automatic test_reset_mid;
      int w0, r0;
      ack_delay = 10;
      issue_op(3'd3, 12, 0, 0, 32'h300, 8);
      @(negedge clk); op_valid = 1'b0;
      @(negedge clk);
      checks++; if (vram_req !== 1'b1) begin failures++; $display("FAIL rstmid_req_before got=%0b exp=1", vram_req); end
      w0 = wcnt; r0 = rcnt;
      rst = 1'b0;
      #1;
      checks++; if (vram_req !== 1'b0 || vrf_we !== 1'b0 || op_ready !== 1'b0) begin
         failures++; $display("FAIL rstmid_drop req=%0b we=%0b ready=%0b exp=0,0,0", vram_req, vrf_we, op_ready); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", op_ready); end
      repeat (15) @(negedge clk);
      checks++; if (wcnt - w0 !== 0 || rcnt - r0 !== 0 || vram_req !== 1'b0) begin
         failures++; $display("FAIL rstmid_stale wr=%0d req=%0d vram_req=%0b exp=0,0,0", wcnt - w0, rcnt - r0, vram_req); end
   endtask

   initial begin
      test_reset();
      test_vadd();
      test_vsub_vmul();
      test_vle();
      test_vse();
      test_edges();
      test_sat();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
